fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decoder. Issues 8-beat wrapping AXI read bursts for the 64-byte line containing the current fetch PC, fills a line buffer critical-word-first, and streams 32-bit instructions with their PC to the decoder over a valid/ready handshake. Handles sequential line crossing and PC redirects, draining any in-flight burst before refetching.

---
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// AXI4 read-address and read-data channels between the fetch unit and memory.
interface fetch_unit_if #(
    parameter int unsigned ID_WIDTH   = 13,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
        input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );

    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
        output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: wrapping 8-beat AXI line fills into a critical-word-first line buffer,
// streaming 32-bit instructions to the decoder with sequential line crossing and redirects.
module fetch_unit #(
    parameter int unsigned ID_WIDTH   = 13,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] entry,
    fetch_unit_if.master          axi,
    output logic [31:0]           inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);
    localparam logic [1:0] StReq   = 2'd0;
    localparam logic [1:0] StData  = 2'd1;
    localparam logic [1:0] StLine  = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;
    localparam int unsigned AW = ADDR_WIDTH;

    logic [1:0]            state_q, state_d;
    logic [AW-1:0]         pc_q, pc_d, araddr_q, araddr_d, redir_pc;
    logic [AW-7:0]         tag_q, tag_d;
    logic [7:0]            vld_q, vld_d, err_q, err_d;
    logic [2:0]            wr_q, wr_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d, drain_q, drain_d;
    logic [DATA_WIDTH-1:0] line_q [8];

    logic [2:0]            cur;
    logic [DATA_WIDTH-1:0] cur_word;
    logic                  in_line, hit, fire, beat, last, store, keep, leave;
    logic                  unused;

    assign cur      = pc_q[5:3];
    assign cur_word = line_q[cur];
    assign in_line  = (state_q == StData) || (state_q == StLine);
    assign hit      = (tag_q == pc_q[AW-1:6]) && vld_q[cur];
    assign beat     = rready_q && axi.m_axi_rvalid;
    assign last     = beat && axi.m_axi_rlast;
    assign store    = beat && (state_q == StData);
    assign redir_pc = {redirect_pc[AW-1:2], 2'b00};
    assign keep     = redirect_valid && in_line && (redirect_pc[AW-1:6] == tag_q);
    assign fire     = inst_valid && inst_ready;
    assign leave    = (redirect_valid && !keep) || (fire && (pc_q[5:2] == 4'hF));
    assign unused   = ^{axi.m_axi_rid, redirect_pc[1:0]};

    assign inst_valid = in_line && hit && !redirect_valid;
    assign inst       = pc_q[2] ? cur_word[63:32] : cur_word[31:0];
    assign inst_pc    = pc_q;
    assign inst_err   = err_q[cur];

    assign axi.m_axi_arid    = {ID_WIDTH{1'b0}};
    assign axi.m_axi_araddr  = araddr_q;
    assign axi.m_axi_arlen   = 8'd7;
    assign axi.m_axi_arsize  = 3'd3;
    assign axi.m_axi_arburst = 2'd2;
    assign axi.m_axi_arlock  = 1'b0;
    assign axi.m_axi_arcache = 4'd0;
    assign axi.m_axi_arprot  = 3'h6;
    assign axi.m_axi_arvalid = arvalid_q;
    assign axi.m_axi_rready  = rready_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        araddr_d  = araddr_q;
        tag_d     = tag_q;
        vld_d     = vld_q;
        err_d     = err_q;
        wr_d      = wr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        drain_d   = drain_q;

        if (redirect_valid) begin
            pc_d = redir_pc;
        end else if (fire) begin
            pc_d = pc_q + {{(AW-3){1'b0}}, 3'd4};
        end

        if (store) begin
            vld_d[wr_q] = 1'b1;
            err_d[wr_q] = |axi.m_axi_rresp;
            wr_d        = wr_q + 3'd1;
        end

        case (state_q)
            StReq: begin
                if (!arvalid_q) begin
                    // Request the line of the (possibly just redirected) pc.
                    arvalid_d = 1'b1;
                    araddr_d  = {pc_d[AW-1:3], 3'b000};
                    tag_d     = pc_d[AW-1:6];
                    vld_d     = '0;
                    drain_d   = 1'b0;
                end else begin
                    if (redirect_valid) drain_d = 1'b1;
                    if (axi.m_axi_arready) begin
                        arvalid_d = 1'b0;
                        rready_d  = 1'b1;
                        wr_d      = araddr_q[5:3];
                        state_d   = (drain_q || redirect_valid) ? StDrain : StData;
                    end
                end
            end
            StData: begin
                if (last) rready_d = 1'b0;
                // A burst that ends on the leaving cycle has nothing left to drain.
                if (leave) begin
                    state_d = last ? StReq : StDrain;
                end else if (last) begin
                    state_d = StLine;
                end
            end
            StDrain: begin
                if (last) begin
                    rready_d = 1'b0;
                    state_d  = StReq;
                end
            end
            StLine: begin
                if (leave) state_d = StReq;
            end
            default: state_d = StReq;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StReq;
            pc_q      <= entry;
            araddr_q  <= '0;
            tag_q     <= '0;
            vld_q     <= '0;
            err_q     <= '0;
            wr_q      <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            drain_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            araddr_q  <= araddr_d;
            tag_q     <= tag_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            drain_q   <= drain_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) line_q[wr_q] <= axi.m_axi_rdata;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: AXI memory responder, sequential-PC reference model and directed tests.
module tb_fetch_unit;
    logic        clk;
    logic        reset;
    logic [63:0] entry;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_err;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    fetch_unit_if #(.ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64)) axi_bus ();

    fetch_unit #(.ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .axi            (axi_bus),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory image: every word encodes its own address.
    function automatic logic [31:0] mem32(input logic [63:0] a);
        return {a[23:0], 8'h13};
    endfunction

    logic        err_en = 1'b0;
    logic [63:0] err_dword = 64'd0;

    function automatic logic err_of(input logic [63:0] a);
        return err_en && (a[63:3] == err_dword[63:3]);
    endfunction

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: inputs change at negedge+1.
    int          ar_delay = 0;
    int          ar_wait = 0;
    logic        s_act = 1'b0;
    int          s_bk = 0;
    logic [63:0] s_base = 64'd0;
    logic        ar_hs_p = 1'b0, r_hs_p = 1'b0;
    logic [63:0] araddr_p = 64'd0;

    initial begin
        logic [2:0]  slot;
        logic [63:0] d;
        axi_bus.m_axi_arready = 1'b0;
        axi_bus.m_axi_rvalid  = 1'b0;
        axi_bus.m_axi_rlast   = 1'b0;
        axi_bus.m_axi_rdata   = 64'd0;
        axi_bus.m_axi_rresp   = 2'd0;
        axi_bus.m_axi_rid     = 13'h1abc;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                s_act = 1'b0;
                s_bk  = 0;
            end else begin
                if (r_hs_p) begin
                    s_bk++;
                    if (s_bk == 8) s_act = 1'b0;
                end
                if (ar_hs_p) begin
                    s_act  = 1'b1;
                    s_base = araddr_p;
                    s_bk   = 0;
                end
            end
            axi_bus.m_axi_arready = reset && axi_bus.m_axi_arvalid && (ar_wait >= ar_delay);
            if (axi_bus.m_axi_arvalid && !axi_bus.m_axi_arready) ar_wait++;
            else ar_wait = 0;
            slot = s_base[5:3] + 3'(s_bk);
            d    = {s_base[63:6], slot, 3'b000};
            axi_bus.m_axi_rvalid = s_act;
            axi_bus.m_axi_rlast  = s_act && (s_bk == 7);
            axi_bus.m_axi_rdata  = {mem32(d + 64'd4), mem32(d)};
            axi_bus.m_axi_rresp  = (s_act && err_en && d[63:3] == err_dword[63:3]) ? 2'd2 : 2'd0;
            ar_hs_p  = axi_bus.m_axi_arvalid && axi_bus.m_axi_arready;
            araddr_p = axi_bus.m_axi_araddr;
            r_hs_p   = axi_bus.m_axi_rvalid && axi_bus.m_axi_rready;
        end
    end

    // Reference model and the single per-cycle compare, at negedge+2.
    logic [63:0] exp_ar [$];
    logic [63:0] exp_pc = 64'd0;
    logic        outst = 1'b0;
    int          accepted = 0, ar_seen = 0, err_seen = 0;
    logic        first_pending = 1'b1;
    logic [63:0] first_pc = 64'd0;
    logic [31:0] first_inst = 32'd0;
    logic        hold_prev = 1'b0;
    logic [63:0] hold_pc = 64'd0;
    logic [31:0] hold_inst = 32'd0;
    logic        prev_ar_hs = 1'b0, prev_ar_pend = 1'b0;
    logic [63:0] prev_araddr = 64'd0;

    initial begin
        logic ar_now;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                chk_eq("reset_outputs", {axi_bus.m_axi_arvalid, axi_bus.m_axi_rready, inst_valid},
                       64'd0);
                chk_eq("reset_araddr", axi_bus.m_axi_araddr, 64'd0);
                exp_pc        = entry;
                outst         = 1'b0;
                accepted      = 0;
                ar_seen       = 0;
                err_seen      = 0;
                first_pending = 1'b1;
                hold_prev     = 1'b0;
                prev_ar_hs    = 1'b0;
                prev_ar_pend  = 1'b0;
            end else begin
                if (inst_valid) begin
                    chk_eq("inst_pc", inst_pc, exp_pc);
                    chk_eq("inst", {32'd0, inst}, {32'd0, mem32(exp_pc)});
                    chk_eq("inst_err", {63'd0, inst_err}, {63'd0, err_of(exp_pc)});
                    if (first_pending) begin
                        first_pc      = inst_pc;
                        first_inst    = inst;
                        first_pending = 1'b0;
                    end
                end
                if (redirect_valid) chk_eq("valid_during_redirect", {63'd0, inst_valid}, 64'd0);
                if (hold_prev && !redirect_valid) begin
                    chk_eq("hold_valid", {63'd0, inst_valid}, 64'd1);
                    chk_eq("hold_pc", inst_pc, hold_pc);
                    chk_eq("hold_inst", {32'd0, inst}, {32'd0, hold_inst});
                end
                hold_prev = inst_valid && !inst_ready && !redirect_valid;
                hold_pc   = inst_pc;
                hold_inst = inst;
                if (redirect_valid) begin
                    exp_pc        = {redirect_pc[63:2], 2'b00};
                    first_pending = 1'b1;
                end else if (inst_valid && inst_ready) begin
                    accepted++;
                    if (inst_err) err_seen++;
                    exp_pc = exp_pc + 64'd4;
                end

                if (prev_ar_hs) chk_eq("arvalid_drop", {63'd0, axi_bus.m_axi_arvalid}, 64'd0);
                if (prev_ar_pend) begin
                    chk_eq("arvalid_hold", {63'd0, axi_bus.m_axi_arvalid}, 64'd1);
                    chk_eq("araddr_hold", axi_bus.m_axi_araddr, prev_araddr);
                end
                if (axi_bus.m_axi_arvalid)
                    chk_eq("ar_fields", {30'd0, axi_bus.m_axi_arid, axi_bus.m_axi_arlen,
                           axi_bus.m_axi_arsize, axi_bus.m_axi_arburst, axi_bus.m_axi_arlock,
                           axi_bus.m_axi_arcache, axi_bus.m_axi_arprot},
                           {30'd0, 13'd0, 8'd7, 3'd3, 2'd2, 1'b0, 4'd0, 3'd6});
                ar_now = axi_bus.m_axi_arvalid && axi_bus.m_axi_arready;
                if (ar_now) begin
                    ar_seen++;
                    chk_eq("ar_expected", {63'd0, exp_ar.size() != 0}, 64'd1);
                    if (exp_ar.size() != 0) chk_eq("araddr", axi_bus.m_axi_araddr, exp_ar.pop_front());
                end
                prev_ar_hs   = ar_now;
                prev_ar_pend = axi_bus.m_axi_arvalid && !axi_bus.m_axi_arready;
                prev_araddr  = axi_bus.m_axi_araddr;

                chk_eq("rready", {63'd0, axi_bus.m_axi_rready}, {63'd0, outst});
                if (ar_now) outst = 1'b1;
                else if (axi_bus.m_axi_rvalid && axi_bus.m_axi_rready && axi_bus.m_axi_rlast)
                    outst = 1'b0;
            end
        end
    end

    task automatic start_test(input logic [63:0] e, input logic [63:0] a0, input logic [63:0] a1);
        @(negedge clk);
        reset          = 1'b0;
        entry          = e;
        redirect_valid = 1'b0;
        exp_ar.delete();
        exp_ar.push_back(a0);
        exp_ar.push_back(a1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #3;
        chk_eq("arvalid_after_reset", {63'd0, axi_bus.m_axi_arvalid}, 64'd1);
        chk_eq("araddr_after_reset", axi_bus.m_axi_araddr, {e[63:3], 3'b000});
    endtask

    task automatic wait_until(input int n_acc, input int n_ar);
        int b = 0;
        do begin
            @(negedge clk);
            b++;
        end while ((accepted < n_acc || ar_seen < n_ar) && b < 400);
        chk_eq("progress_timeout", {63'd0, (accepted >= n_acc && ar_seen >= n_ar)}, 64'd1);
    endtask

    initial begin
        int b;
        int nv;
        reset          = 1'b0;
        entry          = 64'd0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;

        // Aligned line, decoder always ready.
        start_test(64'h1000, 64'h1000, 64'h1040);
        wait_until(16, 2);
        chk_eq("t1_accepted", accepted, 16);
        chk_eq("t1_first_pc", first_pc, 64'h1000);
        chk_eq("t1_first_inst", {32'd0, first_inst}, 64'h0010_0013);

        // Critical word first from slot 3.
        start_test(64'h1018, 64'h1018, 64'h1040);
        b = 0;
        do begin
            @(negedge clk);
            #3;
            b++;
        end while (!(axi_bus.m_axi_rvalid && axi_bus.m_axi_rready) && b < 100);
        @(negedge clk);
        #3;
        chk_eq("t2_valid_after_beat0", {63'd0, inst_valid}, 64'd1);
        chk_eq("t2_pc_after_beat0", inst_pc, 64'h1018);
        chk_eq("t2_inst_after_beat0", {32'd0, inst}, 64'h0010_1813);
        wait_until(10, 2);
        chk_eq("t2_accepted", accepted, 10);

        // Decoder stall mid-line, slow arready.
        ar_delay = 2;
        start_test(64'h1000, 64'h1000, 64'h1040);
        wait_until(4, 1);
        inst_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk_eq("t3_stalled_accepted", accepted, 4);
        inst_ready = 1'b1;
        wait_until(16, 2);
        chk_eq("t3_accepted", accepted, 16);
        ar_delay = 0;

        // Redirect to another line during beat 3.
        start_test(64'h1000, 64'h1000, 64'h2000);
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!(r_hs_p && s_bk == 2) && b < 100);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2004;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk_eq("t4_accepted_before_redirect", accepted, 2);
        nv = 0;
        b  = 0;
        while (ar_seen < 2 && b < 100) begin
            #3;
            if (inst_valid) nv++;
            @(negedge clk);
            b++;
        end
        chk_eq("t4_valid_while_draining", nv, 0);
        wait_until(4, 2);
        chk_eq("t4_first_pc", first_pc, 64'h2004);
        chk_eq("t4_first_inst", {32'd0, first_inst}, 64'h0020_0413);

        // Same-line redirect while the line is full; low pc bits ignored.
        inst_ready = 1'b0;
        start_test(64'h1000, 64'h1000, 64'h1040);
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!(ar_seen >= 1 && !outst) && b < 100);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1031;
        @(negedge clk);
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        #3;
        chk_eq("t5_valid_next_cycle", {63'd0, inst_valid}, 64'd1);
        chk_eq("t5_pc_next_cycle", inst_pc, 64'h1030);
        chk_eq("t5_no_new_ar", ar_seen, 1);
        wait_until(4, 2);
        chk_eq("t5_accepted", accepted, 4);
        chk_eq("t5_first_pc", first_pc, 64'h1030);

        // Error response on beat 1, then reset in the middle of the next burst.
        err_en    = 1'b1;
        err_dword = 64'h1008;
        start_test(64'h1000, 64'h1000, 64'h1040);
        wait_until(16, 2);
        chk_eq("t6_err_count", err_seen, 2);
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!(outst && s_bk >= 2) && b < 100);
        chk_eq("t6_rready_before_reset", {63'd0, axi_bus.m_axi_rready}, 64'd1);
        reset = 1'b0;
        #3;
        chk_eq("t6_reset_same_cycle", {61'd0, axi_bus.m_axi_arvalid, axi_bus.m_axi_rready,
               inst_valid}, 64'd0);
        err_en = 1'b0;
        start_test(64'h2000, 64'h2000, 64'h2040);
        wait_until(1, 1);
        chk_eq("t6_first_pc_after_reset", first_pc, 64'h2000);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
